bus_demux: RTL and testbench

BUS_DEMUX -- requirements
Module: bus_demux

---
 rtl/bus_demux.sv | 151 +++++++++++++++
 tb/tb_bus_demux.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_demux.sv
`default_nettype none
// ============================================================================
// Module      : bus_demux (with bus_demux_pkg and bus_demux_fifo)
// Description : Routes a valid/ready input stream to one of two output ports.
//               Each port buffers words in its own 2-entry FIFO, so the two
//               destinations drain independently and never block each other
//               except through the shared input handshake.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               in_data/in_sel/in_valid     - upstream word, destination, valid
//               in_ready                    - selected FIFO not full
//               outN_data/outN_valid        - head word of port N
//               outN_ready                  - downstream of port N pops head
//               outN_count                  - occupancy of port N (0..2)
// Revision    : 1.0 - initial release
// ============================================================================

// Shared parameter set: every block and bench that needs the bus width
// takes it from here so the value lives in exactly one place.
package bus_demux_pkg;
    localparam int DATA_BUS_WIDTH = 8;
endpackage

// ----------------------------------------------------------------------------
// bus_demux_fifo: 2-entry FIFO with 1-bit pointers and a 2-bit occupancy.
// ----------------------------------------------------------------------------
module bus_demux_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count,
    output logic             full
);
    logic [1:0][WIDTH-1:0] r_mem;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_head_ptr;

    assign full       = (r_count == 2'd2);
    assign head_valid = (r_count != 2'd0);
    assign count      = r_count;

    // A pop on an empty FIFO is meaningless and must not move the pointer.
    assign w_pop  = head_valid & pop_ready;
    // A full FIFO never takes a word, even if it pops in the same cycle.
    assign w_push = push & ~full;

    // When empty, point at the slot that was popped last so the visible data
    // keeps the last head word instead of exposing a stale slot. Nothing can
    // overwrite that slot while the FIFO stays empty.
    assign w_head_ptr = head_valid ? r_rd_ptr : (r_rd_ptr - 1'b1);
    assign head_data  = r_mem[w_head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// ----------------------------------------------------------------------------
// bus_demux: top level
// ----------------------------------------------------------------------------
module bus_demux #(
    parameter int DATA_BUS_WIDTH = bus_demux_pkg::DATA_BUS_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    input  logic                      in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_BUS_WIDTH-1:0] out0_data,
    output logic                      out0_valid,
    input  logic                      out0_ready,
    output logic [1:0]                out0_count,
    output logic [DATA_BUS_WIDTH-1:0] out1_data,
    output logic                      out1_valid,
    input  logic                      out1_ready,
    output logic [1:0]                out1_count
);
    localparam int C_PORTS = 2;

    logic [C_PORTS-1:0]                     w_push;
    logic [C_PORTS-1:0]                     w_pop_ready;
    logic [C_PORTS-1:0][DATA_BUS_WIDTH-1:0] w_head;
    logic [C_PORTS-1:0]                     w_valid;
    logic [C_PORTS-1:0][1:0]                w_count;
    logic [C_PORTS-1:0]                     w_full;
    logic                                   w_accept;

    // Readiness depends only on the addressed FIFO's fullness so it never
    // waits on in_valid or on the other port's state.
    assign in_ready = in_sel ? ~w_full[1] : ~w_full[0];
    assign w_accept = in_valid & in_ready;

    assign w_push      = {w_accept & in_sel, w_accept & ~in_sel};
    assign w_pop_ready = {out1_ready, out0_ready};

    generate
        for (genvar n = 0; n < C_PORTS; n++) begin : g_port
            bus_demux_fifo #(
                .WIDTH (DATA_BUS_WIDTH)
            ) u_fifo (
                .clk        (clk),
                .rst_n      (rst_n),
                .push       (w_push[n]),
                .push_data  (in_data),
                .pop_ready  (w_pop_ready[n]),
                .head_data  (w_head[n]),
                .head_valid (w_valid[n]),
                .count      (w_count[n]),
                .full       (w_full[n])
            );
        end
    endgenerate

    assign out0_data  = w_head[0];
    assign out0_valid = w_valid[0];
    assign out0_count = w_count[0];
    assign out1_data  = w_head[1];
    assign out1_valid = w_valid[1];
    assign out1_count = w_count[1];
endmodule

`default_nettype wire

// File: tb/tb_bus_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_demux
// Description : Self-checking bench for bus_demux. A queue-based reference
//               model tracks each port's contents and is compared against the
//               DUT after every rising edge; directed literal checks pin the
//               model on the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_demux;
    localparam int W = bus_demux_pkg::DATA_BUS_WIDTH;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [1:0]   out0_count;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;
    logic [1:0]   out1_count;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of each port, plus logs of popped words.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] rx0[$];
    logic [W-1:0] rx1[$];
    bit           m_pop0;
    bit           m_pop1;
    bit           m_acc;

    bus_demux #(.DATA_BUS_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Reset empties the model immediately, without waiting for a clock.
    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    // Model update at each rising edge, then compare the DUT against it.
    always begin
        @(posedge clk);
        if (rst_n) begin
            m_pop0 = (q0.size() > 0) && out0_ready;
            m_pop1 = (q1.size() > 0) && out1_ready;
            m_acc  = in_valid && ((in_sel ? q1.size() : q0.size()) < 2);
            if (m_pop0) rx0.push_back(q0.pop_front());
            if (m_pop1) rx1.push_back(q1.pop_front());
            if (m_acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
        #1;
        chk("cmp out0_count", 32'(out0_count), 32'(q0.size()));
        chk("cmp out1_count", 32'(out1_count), 32'(q1.size()));
        chk("cmp out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("cmp out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        chk("cmp in_ready", 32'(in_ready), 32'((in_sel ? q1.size() : q0.size()) < 2));
        if (q0.size() != 0) chk("cmp out0_data", 32'(out0_data), 32'(q0[0]));
        if (q1.size() != 0) chk("cmp out1_data", 32'(out1_data), 32'(q1[0]));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out0_valid", 32'(out0_valid), 32'd0);
        chk("reset out1_valid", 32'(out1_valid), 32'd0);
        chk("reset out0_count", 32'(out0_count), 32'd0);
        chk("reset out1_count", 32'(out1_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single route to port 1.
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("route out1_valid", 32'(out1_valid), 32'd1);
        chk("route out1_data", 32'(out1_data), 32'hA5);
        chk("route out1_count", 32'(out1_count), 32'd1);
        chk("route out0_valid", 32'(out0_valid), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain out1_valid", 32'(out1_valid), 32'd0);

        // Ready on an empty port must not underflow.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        chk("underflow out0_count", 32'(out0_count), 32'd0);
        chk("underflow out1_count", 32'(out1_count), 32'd0);

        // Fill port 0 and observe backpressure.
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("fill out0_count", 32'(out0_count), 32'd2);
        chk("fill in_ready sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1;
        chk("fill in_ready sel1", 32'(in_ready), 32'd1);
        in_sel = 1'b0;

        // Full port pops while a push is offered: push refused.
        drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("fullpop out0_count", 32'(out0_count), 32'd1);
        chk("fullpop out0_data", 32'(out0_data), 32'h22);
        chk("fullpop popped", 32'(rx0[rx0.size()-1]), 32'h11);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("fullpop drained", 32'(out0_valid), 32'd0);

        // Streaming to port 1 with a continuously ready consumer.
        rx1.delete();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, W'(i), 1'b0, 1'b1);
            @(negedge clk);
            chk("stream out1_data", 32'(out1_data), 32'(i));
            chk("stream count<=1", 32'(out1_count <= 2'd1), 32'd1);
            chk("stream in_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("stream final count", 32'(out1_count), 32'd0);
        chk("stream rx count", 32'(rx1.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx1.size(); i++)
            chk("stream order", 32'(rx1[i]), 32'(i + 1));

        // Interleaved routing.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i % 2), W'(8'h10 + i), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("ilv out0_count", 32'(out0_count), 32'd2);
        chk("ilv out1_count", 32'(out1_count), 32'd2);
        chk("ilv out0 head", 32'(out0_data), 32'h10);
        chk("ilv out1 head", 32'(out1_data), 32'h11);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ilv out0 second", 32'(out0_data), 32'h12);
        chk("ilv out1 second", 32'(out1_data), 32'h13);

        // Push to port 0 while both ports pop.
        drive(1'b1, 1'b0, 8'h14, 1'b1, 1'b1);
        @(negedge clk);
        chk("dual out0_count", 32'(out0_count), 32'd1);
        chk("dual out0_data", 32'(out0_data), 32'h14);
        chk("dual out1_count", 32'(out1_count), 32'd0);

        // Fill both ports, then reset between clock edges.
        drive(1'b1, 1'b0, 8'h15, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h16, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h17, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("prerst out0_count", 32'(out0_count), 32'd2);
        chk("prerst out1_count", 32'(out1_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("asyncrst out0_count", 32'(out0_count), 32'd0);
        chk("asyncrst out1_count", 32'(out1_count), 32'd0);
        chk("asyncrst out0_valid", 32'(out0_valid), 32'd0);
        chk("asyncrst out1_valid", 32'(out1_valid), 32'd0);
        chk("asyncrst out0_data", 32'(out0_data), 32'd0);
        chk("asyncrst out1_data", 32'(out1_data), 32'd0);
        chk("asyncrst in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        chk("inrst no accept", 32'(out0_count), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h7E, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("postrst out0_valid", 32'(out0_valid), 32'd1);
        chk("postrst out0_data", 32'(out0_data), 32'h7E);
        chk("postrst out0_count", 32'(out0_count), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
